fusion_mac_pe: RTL and testbench
================================

// Module: fusion_mac_pe
// PURPOSE
//  Pipelined, precision-fusible multiply-accumulate PE for the systolic column; successor to the fixed-precision
//  combinational MAC. One packed 8-bit activation/weight pair per beat is split into 1x8b, 2x4b or 4x2b lanes; lane
//  products are summed, accumulated over a multi-beat group and emitted as psum_in + group sum with valid/ready.
// PARAMETERS
//  COL_WIDTH   11  half-width of partial sum; ACC_WIDTH = 2*COL_WIDTH (22) is the psum_in/psum_fwd width
//  ACC_GUARD   8   extra guard bits in the internal accumulator (internal width ACC_WIDTH+ACC_GUARD, signed)
//  SATURATE    1   1: clamp psum_fwd to signed ACC_WIDTH range; 0: truncate (wrap) to ACC_WIDTH bits
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          beat valid
//  in_ready   out  1          beat accepted when in_valid & in_ready
//  in         in   8          packed activation lanes (lane 0 = LSBs)
//  weight     in   8          packed weight lanes (lane 0 = LSBs)
//  s_in       in   1          1: activation lanes signed two's complement
//  s_weight   in   1          1: weight lanes signed two's complement
//  mode       in   2          00: 1x8b, 01: 2x4b, 10: 4x2b, 11: reserved (beat treated as zero product)
//  last       in   1          final beat of an accumulation group
//  psum_in    in   ACC_WIDTH  incoming partial sum (signed), sampled with the last beat only
//  out_valid  out  1          psum_fwd valid
//  out_ready  in   1          downstream accepts psum_fwd
//  psum_fwd   out  ACC_WIDTH  psum_in + group sum (signed)
//  out_sat    out  1          result was clamped (SATURATE=1) or overflowed (SATURATE=0)
// BEHAVIOUR
//  - Reset: in_ready=1 after the reset edge; out_valid=0, psum_fwd=0, out_sat=0; accumulator=0; all stage valids=0.
//  - Stall = out_valid & ~out_ready. in_ready = ~stall. On stall, every pipeline register holds; nothing is lost.
//  - Stage S1 (accept edge): register in, weight, s_in, s_weight, mode, last, psum_in.
//  - Stage S2 (next edge): lane products, each lane sign/zero-extended per s_in/s_weight independently, summed
//    into a signed 18-bit beat sum. mode is per beat; mixed modes within a group are legal.
//  - Stage S3 (next edge): acc += beat sum. If beat was last: psum_fwd = sat/trunc(acc + beat + psum_in),
//    out_valid=1, acc cleared to 0 on the same edge. Non-last beats never raise out_valid.
//  - Latency: last beat accepted on edge N -> out_valid=1 after edge N+2. Throughput 1 beat/clk when unstalled.
//  - out_valid drops on the edge where out_valid & out_ready, unless a new result is produced on that edge.
//  - Saturation: internal sum compared to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; out of range -> clamp (or
//    wrap if SATURATE=0) and out_sat=1 for that result. Internal guard overflow is a usage error (undefined).
//  - in_valid=0 beats insert bubbles; accumulator retained across bubbles indefinitely.
//  - rst mid-group: in-flight beats and partial accumulator discarded; first post-reset group starts from 0.
//  - mode=11: beat counts toward the group (last honoured) with beat sum 0.
// TESTING
//  1) 1x8b signed: in=8'hFF, weight=8'h02, s_in=s_weight=1, last=1, psum_in=10 -> psum_fwd=8, 2 clk after accept.
//  2) 2x4b: in=8'h21, weight=8'h43 unsigned -> 11; in=8'hF1, weight=8'h22, s_in=1, s_weight=0 -> 0.
//  3) 4x2b: in=8'hFF, weight=8'h55, s_in=1, s_weight=0 -> -4; same operands both unsigned -> 12.
//  4) Group: 4 beats 1x8b unsigned 255*255, last on 4th, psum_in=0 -> 260100, out_sat=0; 40 such beats
//     -> psum_fwd=2097151, out_sat=1 (SATURATE=1).
//  5) Backpressure: out_ready=0 for 5 clk with result pending -> in_ready=0, psum_fwd stable; release -> next
//     groups emerge in order, none dropped or duplicated; back-to-back 1-beat groups give 1 result/clk.
//  6) Assert rst after 2 beats of a group -> outputs return to reset values; next 1-beat group 3*3, psum_in=0 -> 9.

Source files
------------

// File: rtl/fusion_mac_pe_if.sv
// Beat/result handshake bundle for the precision-fusible MAC PE.
// The master drives beats and result back-pressure; the slave is the PE.
interface fusion_mac_pe_if #(
  parameter int unsigned ACC_WIDTH = 22
);
  logic                        in_valid;
  logic                        in_ready;
  logic [7:0]                  in;
  logic [7:0]                  weight;
  logic                        s_in;
  logic                        s_weight;
  logic [1:0]                  mode;
  logic                        last;
  logic signed [ACC_WIDTH-1:0] psum_in;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] psum_fwd;
  logic                        out_sat;

  modport master (
    output in_valid, in, weight, s_in, s_weight, mode, last, psum_in, out_ready,
    input  in_ready, out_valid, psum_fwd, out_sat
  );

  modport slave (
    input  in_valid, in, weight, s_in, s_weight, mode, last, psum_in, out_ready,
    output in_ready, out_valid, psum_fwd, out_sat
  );
endinterface

// File: rtl/fusion_mac_pe.sv
// Three-stage precision-fusible MAC PE: register beat, form lane-product sum, accumulate
// over a group and emit psum_in + group sum with saturation or wrap.
module fusion_mac_pe #(
  parameter int unsigned COL_WIDTH = 11,
  parameter int unsigned ACC_GUARD = 8,
  parameter bit          SATURATE  = 1'b1
) (
  input logic            clk,
  input logic            rst,
  fusion_mac_pe_if.slave bus
);
  localparam int unsigned ACC_WIDTH = 2 * COL_WIDTH;
  localparam int unsigned IntWidth  = ACC_WIDTH + ACC_GUARD;
  localparam int unsigned BeatW     = 18;

  logic advance;

  // Stage 1: captured beat
  logic                        s1_valid_q;
  logic [7:0]                  s1_in_q;
  logic [7:0]                  s1_weight_q;
  logic                        s1_s_in_q;
  logic                        s1_s_weight_q;
  logic [1:0]                  s1_mode_q;
  logic                        s1_last_q;
  logic signed [ACC_WIDTH-1:0] s1_psum_q;

  // Stage 2: beat sum
  logic                        s2_valid_q;
  logic signed [BeatW-1:0]     s2_beat_q;
  logic                        s2_last_q;
  logic signed [ACC_WIDTH-1:0] s2_psum_q;

  // Stage 3: accumulator and result
  logic signed [IntWidth-1:0]  acc_q;
  logic                        out_valid_q;
  logic signed [ACC_WIDTH-1:0] psum_fwd_q;
  logic                        out_sat_q;

  logic signed [BeatW-1:0]     beat_sum;
  logic signed [8:0]           a9, w9;
  logic signed [17:0]          p18;
  logic signed [4:0]           a5, w5;
  logic signed [9:0]           p10;
  logic signed [2:0]           a3, w3;
  logic signed [5:0]           p6;
  logic signed [IntWidth-1:0]  acc_sum;
  logic signed [IntWidth-1:0]  total;
  logic                        ovf;
  logic signed [ACC_WIDTH-1:0] result;

  // A pending result that is not taken freezes the whole pipe.
  assign advance       = ~(out_valid_q & ~bus.out_ready);
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.psum_fwd  = psum_fwd_q;
  assign bus.out_sat   = out_sat_q;

  always_comb begin
    beat_sum = '0;
    a9 = '0; w9 = '0; p18 = '0;
    a5 = '0; w5 = '0; p10 = '0;
    a3 = '0; w3 = '0; p6 = '0;
    case (s1_mode_q)
      2'b00: begin
        a9       = {s1_s_in_q & s1_in_q[7], s1_in_q};
        w9       = {s1_s_weight_q & s1_weight_q[7], s1_weight_q};
        p18      = a9 * w9;
        beat_sum = p18;
      end
      2'b01: begin
        for (int i = 0; i < 2; i++) begin
          a5       = {s1_s_in_q & s1_in_q[4*i+3], s1_in_q[4*i+:4]};
          w5       = {s1_s_weight_q & s1_weight_q[4*i+3], s1_weight_q[4*i+:4]};
          p10      = a5 * w5;
          beat_sum = beat_sum + {{(BeatW-10){p10[9]}}, p10};
        end
      end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          a3       = {s1_s_in_q & s1_in_q[2*i+1], s1_in_q[2*i+:2]};
          w3       = {s1_s_weight_q & s1_weight_q[2*i+1], s1_weight_q[2*i+:2]};
          p6       = a3 * w3;
          beat_sum = beat_sum + {{(BeatW-6){p6[5]}}, p6};
        end
      end
      default: beat_sum = '0;
    endcase
  end

  always_comb begin
    acc_sum = acc_q + {{(IntWidth-BeatW){s2_beat_q[BeatW-1]}}, s2_beat_q};
    total   = acc_sum + {{ACC_GUARD{s2_psum_q[ACC_WIDTH-1]}}, s2_psum_q};
    // Out of range when the bits above the result sign are not a pure sign extension.
    ovf     = total[IntWidth-1:ACC_WIDTH-1] != {(ACC_GUARD+1){total[IntWidth-1]}};
    result  = total[ACC_WIDTH-1:0];
    if (ovf && SATURATE) begin
      result = total[IntWidth-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_in_q       <= '0;
      s1_weight_q   <= '0;
      s1_s_in_q     <= 1'b0;
      s1_s_weight_q <= 1'b0;
      s1_mode_q     <= '0;
      s1_last_q     <= 1'b0;
      s1_psum_q     <= '0;
    end else if (advance) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_in_q       <= bus.in;
        s1_weight_q   <= bus.weight;
        s1_s_in_q     <= bus.s_in;
        s1_s_weight_q <= bus.s_weight;
        s1_mode_q     <= bus.mode;
        s1_last_q     <= bus.last;
        s1_psum_q     <= bus.psum_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_beat_q   <= '0;
      s2_last_q   <= 1'b0;
      s2_psum_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      psum_fwd_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_beat_q <= beat_sum;
        s2_last_q <= s1_last_q;
        s2_psum_q <= s1_psum_q;
      end
      out_valid_q <= s2_valid_q & s2_last_q;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          acc_q      <= '0;
          psum_fwd_q <= result;
          out_sat_q  <= ovf;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_fusion_mac_pe.sv
// Directed-vector bench for fusion_mac_pe: lane modes, grouping, saturation,
// back-pressure ordering and mid-group reset.
module tb_fusion_mac_pe;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fusion_mac_pe_if #(.ACC_WIDTH(22)) bus ();

  fusion_mac_pe #(
    .COL_WIDTH(11),
    .ACC_GUARD(8),
    .SATURATE (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] w, input logic sa,
                           input logic sw, input logic [1:0] md, input logic lst,
                           input int ps);
    int n;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.in       = a;
    bus.weight   = w;
    bus.s_in     = sa;
    bus.s_weight = sw;
    bus.mode     = md;
    bus.last     = lst;
    bus.psum_in  = 22'(ps);
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check_val("accept_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int exp, input int exp_sat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    check_val({tag, "_valid"}, int'(bus.out_valid), 1);
    check_val(tag, bus.psum_fwd, exp);
    check_val({tag, "_sat"}, int'(bus.out_sat), exp_sat);
    tick();
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.weight    = '0;
    bus.s_in      = 1'b0;
    bus.s_weight  = 1'b0;
    bus.mode      = '0;
    bus.last      = 1'b0;
    bus.psum_in   = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    check_val("rst_in_ready", int'(bus.in_ready), 1);
    check_val("rst_out_valid", int'(bus.out_valid), 0);
    check_val("rst_psum", bus.psum_fwd, 0);
    check_val("rst_sat", int'(bus.out_sat), 0);

    // 1x8b signed, exact two-edge latency
    send_beat(8'hFF, 8'h02, 1'b1, 1'b1, 2'b00, 1'b1, 10);
    check_val("t1_lat0", int'(bus.out_valid), 0);
    tick();
    check_val("t1_lat1", int'(bus.out_valid), 0);
    tick();
    check_val("t1_valid", int'(bus.out_valid), 1);
    check_val("t1_psum", bus.psum_fwd, 8);
    check_val("t1_sat", int'(bus.out_sat), 0);
    tick();
    check_val("t1_drop", int'(bus.out_valid), 0);

    send_beat(8'h21, 8'h43, 1'b0, 1'b0, 2'b01, 1'b1, 0);
    expect_result("t2_uu", 11, 0);
    send_beat(8'hF1, 8'h22, 1'b1, 1'b0, 2'b01, 1'b1, 0);
    expect_result("t2_su", 0, 0);

    send_beat(8'hFF, 8'h55, 1'b1, 1'b0, 2'b10, 1'b1, 0);
    expect_result("t3_su", -4, 0);
    send_beat(8'hFF, 8'h55, 1'b0, 1'b0, 2'b10, 1'b1, 0);
    expect_result("t3_uu", 12, 0);

    for (int i = 0; i < 4; i++) send_beat(8'hFF, 8'hFF, 1'b0, 1'b0, 2'b00, i == 3, 0);
    expect_result("t4_grp4", 260100, 0);
    for (int i = 0; i < 40; i++) send_beat(8'hFF, 8'hFF, 1'b0, 1'b0, 2'b00, i == 39, 0);
    expect_result("t4_grp40", 2097151, 1);

    send_beat(8'hFF, 8'h01, 1'b1, 1'b1, 2'b00, 1'b1, -2097152);
    expect_result("neg_clamp", -2097152, 1);

    // Mixed modes, bubbles and a reserved-mode beat inside one group: 11 + 12 + 0 + 6 + 100
    send_beat(8'h21, 8'h43, 1'b0, 1'b0, 2'b01, 1'b0, 0);
    repeat (2) tick();
    send_beat(8'hFF, 8'h55, 1'b0, 1'b0, 2'b10, 1'b0, 0);
    send_beat(8'hFF, 8'hFF, 1'b1, 1'b1, 2'b11, 1'b0, 0);
    repeat (3) tick();
    send_beat(8'h02, 8'h03, 1'b0, 1'b0, 2'b00, 1'b1, 100);
    expect_result("mixed", 129, 0);
    send_beat(8'hAA, 8'hBB, 1'b0, 1'b0, 2'b11, 1'b1, 5);
    expect_result("rsvd_last", 5, 0);

    // Back-pressure with three groups in flight
    bus.out_ready = 1'b0;
    send_beat(8'h03, 8'h05, 1'b0, 1'b0, 2'b00, 1'b1, 0);
    send_beat(8'h04, 8'h05, 1'b0, 1'b0, 2'b00, 1'b1, 0);
    send_beat(8'h06, 8'h05, 1'b0, 1'b0, 2'b00, 1'b1, 0);
    check_val("t5_pend_valid", int'(bus.out_valid), 1);
    check_val("t5_pend_psum", bus.psum_fwd, 15);
    check_val("t5_pend_ready", int'(bus.in_ready), 0);
    repeat (5) begin
      tick();
      check_val("t5_hold_psum", bus.psum_fwd, 15);
      check_val("t5_hold_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    check_val("t5_a", bus.psum_fwd, 15);
    tick();
    check_val("t5_b_valid", int'(bus.out_valid), 1);
    check_val("t5_b", bus.psum_fwd, 20);
    tick();
    check_val("t5_c_valid", int'(bus.out_valid), 1);
    check_val("t5_c", bus.psum_fwd, 30);
    tick();
    check_val("t5_empty", int'(bus.out_valid), 0);

    // Back-to-back 1-beat groups, one result per clock
    send_beat(8'h01, 8'h01, 1'b0, 1'b0, 2'b00, 1'b1, 1);
    send_beat(8'h02, 8'h02, 1'b0, 1'b0, 2'b00, 1'b1, 0);
    send_beat(8'h03, 8'h03, 1'b0, 1'b0, 2'b00, 1'b1, 0);
    check_val("b2b_d_valid", int'(bus.out_valid), 1);
    check_val("b2b_d", bus.psum_fwd, 2);
    tick();
    check_val("b2b_e_valid", int'(bus.out_valid), 1);
    check_val("b2b_e", bus.psum_fwd, 4);
    tick();
    check_val("b2b_f_valid", int'(bus.out_valid), 1);
    check_val("b2b_f", bus.psum_fwd, 9);
    tick();
    check_val("b2b_empty", int'(bus.out_valid), 0);

    // Reset with a saturated result pending and a partial group in flight
    bus.out_ready = 1'b0;
    send_beat(8'h01, 8'h01, 1'b0, 1'b0, 2'b00, 1'b1, 2097151);
    send_beat(8'h64, 8'h64, 1'b0, 1'b0, 2'b00, 1'b0, 0);
    send_beat(8'h64, 8'h64, 1'b0, 1'b0, 2'b00, 1'b0, 0);
    check_val("t6_pre_valid", int'(bus.out_valid), 1);
    check_val("t6_pre_psum", bus.psum_fwd, 2097151);
    check_val("t6_pre_sat", int'(bus.out_sat), 1);
    rst = 1'b1;
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    check_val("t6_rst_valid", int'(bus.out_valid), 0);
    check_val("t6_rst_psum", bus.psum_fwd, 0);
    check_val("t6_rst_sat", int'(bus.out_sat), 0);
    check_val("t6_rst_ready", int'(bus.in_ready), 1);
    repeat (3) tick();
    check_val("t6_no_stray", int'(bus.out_valid), 0);
    send_beat(8'h03, 8'h03, 1'b0, 1'b0, 2'b00, 1'b1, 0);
    expect_result("t6_post", 9, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
